loop3_result_drain: RTL

Consumer for the channel-loop accumulator's finished 64x16b result vector. Captures each 1024-bit vector presented with a valid strobe, then streams it downstream as 16 beats of 64 bits (4 x 16b lanes) over a valid/ready handshake, with optional per-lane ReLU. A two-slot buffer absorbs one result while the previous one drains. `halt` back-pressures the accumulator when both slots are occupied.

---
 rtl/loop3_result_drain.sv | 92 +++++++++
 1 files changed

// File: rtl/loop3_result_drain.sv
// Result drain: captures 64x16b accumulator vectors into a two-slot buffer
// and streams them out as 16 beats of 4 lanes with optional ReLU.
module loop3_result_drain #(
    parameter bit RELU_EN = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          loop3_regdata_v,
    input  logic [1023:0] loop3_regdata_w,
    output logic          halt,
    output logic          out_v,
    input  logic          out_ready,
    output logic [63:0]   out_data,
    output logic          out_last,
    output logic [15:0]   frame_cnt
);

    logic          act_full;
    logic          pend_full;
    logic [1023:0] act_buf;
    logic [1023:0] pend_buf;
    logic [3:0]    beat_cnt;

    logic fire;
    logic last_fire;
    logic accept;
    logic act_free;
    logic load_act_pend;
    logic load_act_in;
    logic load_pend;

    assign fire      = act_full & out_ready;
    assign last_fire = fire & (beat_cnt == 4'hF);
    assign accept    = loop3_regdata_v & ~pend_full;
    assign act_free  = ~act_full | last_fire;

    // Pending always has priority for the active slot; halt keeps
    // accept and pending-move mutually exclusive.
    assign load_act_pend = act_free & pend_full;
    assign load_act_in   = act_free & ~pend_full & accept;
    assign load_pend     = ~act_free & accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            act_full  <= 1'b0;
            pend_full <= 1'b0;
            beat_cnt  <= 4'd0;
            frame_cnt <= 16'd0;
        end else begin
            if (fire)
                beat_cnt <= beat_cnt + 4'd1;
            if (last_fire)
                frame_cnt <= frame_cnt + 16'd1;
            if (act_free)
                act_full <= load_act_pend | load_act_in;
            if (load_act_pend)
                pend_full <= 1'b0;
            else if (load_pend)
                pend_full <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (load_act_pend)
            act_buf <= pend_buf;
        else if (load_act_in)
            act_buf <= loop3_regdata_w;
        if (load_pend)
            pend_buf <= loop3_regdata_w;
    end

    logic [63:0] beat_raw;

    assign beat_raw = act_buf[{beat_cnt, 6'd0} +: 64];

    always_comb begin
        out_data = '0;
        if (act_full) begin
            for (int j = 0; j < 4; j++) begin
                if (RELU_EN && beat_raw[16*j+15])
                    out_data[16*j +: 16] = 16'h0000;
                else
                    out_data[16*j +: 16] = beat_raw[16*j +: 16];
            end
        end
    end

    assign out_last = act_full & (beat_cnt == 4'hF);
    assign out_v    = act_full;
    assign halt     = pend_full;

endmodule
